// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the RV32I core.
// One fetch outstanding at a time; a one-entry hold buffer absorbs decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is accepted on any cycle with imem_req & imem_ready;
  // its single response arrives on a later cycle with imem_rvalid.

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_d_q;
  logic [31:0] pc_plus4_q;

  logic        slot_free;
  logic        new_avail;
  logic [31:0] new_word;
  logic [31:0] new_pc;
  logic [1:0]  unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];

  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign valid_d     = valid_q;
  assign instr_d     = instr_q;
  assign pc_d        = pc_d_q;
  assign pc_plus4_d  = pc_plus4_q;
  assign dbg_state_o = state_q;

  assign slot_free = !valid_q || !stall_d;

  // A word is offered to the slot either straight from memory or from the hold buffer.
  always_comb begin
    new_avail = 1'b0;
    new_word  = imem_rdata;
    new_pc    = req_pc_q;
    if (state_q == S_WAIT && imem_rvalid) begin
      new_avail = 1'b1;
    end else if (state_q == S_HOLD) begin
      new_avail = 1'b1;
      new_word  = hold_instr_q;
      new_pc    = hold_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_d_q       <= 32'h0;
      pc_plus4_q   <= 32'h0;
    end else if (redirect) begin
      // Leaving S_HOLD is what invalidates the hold buffer.
      pc_q    <= {redirect_pc[31:2], 2'b00};
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      case (state_q)
        S_REQ:   state_q <= imem_ready  ? S_DROP : S_REQ;
        S_WAIT:  state_q <= imem_rvalid ? S_REQ  : S_DROP;
        S_HOLD:  state_q <= S_REQ;
        S_DROP:  state_q <= imem_rvalid ? S_REQ  : S_DROP;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            req_pc_q <= pc_q;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            pc_q <= req_pc_q + 32'd4;
            if (slot_free) begin
              state_q <= S_REQ;
            end else begin
              hold_instr_q <= imem_rdata;
              hold_pc_q    <= req_pc_q;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free) state_q <= S_REQ;
        end
        S_DROP: begin
          if (imem_rvalid) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase

      if (new_avail && slot_free) begin
        valid_q    <= 1'b1;
        instr_q    <= new_word;
        pc_d_q     <= new_pc;
        pc_plus4_q <= new_pc + 32'd4;
      end else if (valid_q && !stall_d) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors for free-run and
// stall/hold, then hand-written sequences for redirect, wrap and reset corners.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_HOLD = 2'd2, ST_DROP = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall_d = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_err = 0;

  // Memory model state: pending response and its latency in cycles.
  int          lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .dbg_state_o(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return a ^ 32'h5A00_0013;
  endfunction

  // Acceptance is sampled mid-cycle; responses are presented just after an edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) pend = 1'b0;
      else if (imem_req && imem_ready) begin
        pend = 1'b1; pend_addr = imem_addr; pend_cnt = lat;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt <= 1) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 1'b0;
        end else begin
          pend_cnt = pend_cnt - 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the bench just after the first edge with rst low (cycle C0).
  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; stall_d = 1'b0; imem_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [1:0]  st;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] a,
                              input logic v, input logic [31:0] i, input logic [31:0] p,
                              input logic [31:0] p4, input logic [1:0] st);
    vec_t t;
    t.stall = s; t.req = r; t.addr = a; t.valid = v;
    t.instr = i; t.pc = p; t.pc4 = p4; t.st = st;
    return t;
  endfunction

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(0, 1, 32'h0,  0, NOP,               32'h0, 32'h0,  ST_REQ);
    vecs[1]  = mk(0, 0, 32'h0,  0, NOP,               32'h0, 32'h0,  ST_WAIT);
    vecs[2]  = mk(0, 1, 32'h4,  1, 32'h0050_0093,     32'h0, 32'h4,  ST_REQ);
    vecs[3]  = mk(0, 0, 32'h4,  0, NOP,               32'h0, 32'h4,  ST_WAIT);
    vecs[4]  = mk(1, 1, 32'h8,  1, 32'h00A0_0113,     32'h4, 32'h8,  ST_REQ);
    vecs[5]  = mk(1, 0, 32'h8,  1, 32'h00A0_0113,     32'h4, 32'h8,  ST_WAIT);
    vecs[6]  = mk(1, 0, 32'hC,  1, 32'h00A0_0113,     32'h4, 32'h8,  ST_HOLD);
    vecs[7]  = mk(1, 0, 32'hC,  1, 32'h00A0_0113,     32'h4, 32'h8,  ST_HOLD);
    vecs[8]  = mk(1, 0, 32'hC,  1, 32'h00A0_0113,     32'h4, 32'h8,  ST_HOLD);
    vecs[9]  = mk(0, 0, 32'hC,  1, 32'h00A0_0113,     32'h4, 32'h8,  ST_HOLD);
    vecs[10] = mk(0, 1, 32'hC,  1, mem_word(32'h8),   32'h8, 32'hC,  ST_REQ);
    vecs[11] = mk(0, 0, 32'hC,  0, NOP,               32'h8, 32'hC,  ST_WAIT);
    vecs[12] = mk(0, 1, 32'h10, 1, mem_word(32'hC),   32'hC, 32'h10, ST_REQ);

    // Reset values while rst is held high.
    rst = 1'b1; lat = 1;
    step();
    @(negedge clk);
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, valid_d},  32'h0);
    chk("rst_instr", instr_d,           NOP);
    chk("rst_pc_d",  pc_d,              32'h0);
    chk("rst_pc4",   pc_plus4_d,        32'h0);

    // Free-run with 1-cycle memory, then a 5-cycle stall forcing the hold buffer.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      stall_d = vecs[k].stall;
      @(negedge clk);
      chk($sformatf("v%0d_req", k),   {31'h0, imem_req}, {31'h0, vecs[k].req});
      chk($sformatf("v%0d_addr", k),  imem_addr,         vecs[k].addr);
      chk($sformatf("v%0d_valid", k), {31'h0, valid_d},  {31'h0, vecs[k].valid});
      chk($sformatf("v%0d_instr", k), instr_d,           vecs[k].instr);
      chk($sformatf("v%0d_pc", k),    pc_d,              vecs[k].pc);
      chk($sformatf("v%0d_pc4", k),   pc_plus4_d,        vecs[k].pc4);
      chk($sformatf("v%0d_state", k), {30'h0, dbg_state}, {30'h0, vecs[k].st});
      step();
    end
    stall_d = 1'b0;

    // Redirect in S_WAIT, stale response arrives two cycles later.
    lat = 3;
    do_reset();
    @(negedge clk); step();                       // C0: accept addr 0
    redirect = 1'b1; redirect_pc = 32'h0000_0103; // C1
    @(negedge clk);
    chk("a1_state", {30'h0, dbg_state}, {30'h0, ST_WAIT});
    step(); redirect = 1'b0;                      // C2
    @(negedge clk);
    chk("a2_state", {30'h0, dbg_state}, {30'h0, ST_DROP});
    chk("a2_req",   {31'h0, imem_req},  32'h0);
    chk("a2_valid", {31'h0, valid_d},   32'h0);
    step();                                       // C3: stale rvalid
    @(negedge clk);
    chk("a3_rvalid", {31'h0, imem_rvalid}, 32'h1);
    chk("a3_valid",  {31'h0, valid_d},     32'h0);
    step(); lat = 1;                              // C4
    @(negedge clk);
    chk("a4_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
    chk("a4_req",   {31'h0, imem_req},  32'h1);
    chk("a4_addr",  imem_addr,          32'h0000_0100);
    chk("a4_valid", {31'h0, valid_d},   32'h0);
    step(); @(negedge clk);                       // C5
    chk("a5_valid", {31'h0, valid_d}, 32'h0);
    step(); @(negedge clk);                       // C6
    chk("a6_valid", {31'h0, valid_d}, 32'h1);
    chk("a6_instr", instr_d,          mem_word(32'h100));
    chk("a6_pc",    pc_d,             32'h100);
    chk("a6_pc4",   pc_plus4_d,       32'h104);

    // Redirect coincident with rvalid, then with stall_d=1 & valid_d=1.
    lat = 1;
    do_reset();
    @(negedge clk); step();                       // C0: accept
    redirect = 1'b1; redirect_pc = 32'h0000_0200; // C1: rvalid too
    @(negedge clk);
    chk("b1_rvalid", {31'h0, imem_rvalid}, 32'h1);
    step(); redirect = 1'b0;                      // C2
    @(negedge clk);
    chk("b2_valid", {31'h0, valid_d},   32'h0);
    chk("b2_instr", instr_d,            NOP);
    chk("b2_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
    chk("b2_addr",  imem_addr,          32'h0000_0200);
    step(); @(negedge clk); step();               // C3: response
    stall_d = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300; // C4
    @(negedge clk);
    chk("c4_valid", {31'h0, valid_d}, 32'h1);
    chk("c4_instr", instr_d,          mem_word(32'h200));
    chk("c4_addr",  imem_addr,        32'h0000_0204);
    step(); stall_d = 1'b0; redirect = 1'b0;      // C5
    @(negedge clk);
    chk("c5_valid", {31'h0, valid_d},   32'h0);
    chk("c5_instr", instr_d,            NOP);
    chk("c5_state", {30'h0, dbg_state}, {30'h0, ST_DROP});
    step(); @(negedge clk);                       // C6
    chk("c6_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
    chk("c6_addr",  imem_addr,          32'h0000_0300);
    chk("c6_valid", {31'h0, valid_d},   32'h0);

    // Fetch at 0xFFFFFFFC wraps, then a 1-cycle reset while in S_WAIT.
    lat = 1;
    do_reset();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; // C0
    @(negedge clk);
    step(); imem_ready = 1'b1; redirect = 1'b0;   // C1
    @(negedge clk);
    chk("d1_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
    chk("d1_addr",  imem_addr,          32'hFFFF_FFFC);
    step(); @(negedge clk); step();               // C2: response
    lat = 3;                                      // C3
    @(negedge clk);
    chk("d3_valid", {31'h0, valid_d}, 32'h1);
    chk("d3_pc",    pc_d,             32'hFFFF_FFFC);
    chk("d3_pc4",   pc_plus4_d,       32'h0);
    chk("d3_instr", instr_d,          mem_word(32'hFFFF_FFFC));
    chk("d3_addr",  imem_addr,        32'h0);
    step();                                       // C4: S_WAIT
    chk("e4_state", {30'h0, dbg_state}, {30'h0, ST_WAIT});
    rst = 1'b1;
    @(negedge clk);
    chk("e4_req", {31'h0, imem_req}, 32'h0);
    step(); rst = 1'b0;                           // C5
    @(negedge clk);
    chk("e5_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
    chk("e5_req",   {31'h0, imem_req},  32'h1);
    chk("e5_addr",  imem_addr,          32'h0);
    chk("e5_valid", {31'h0, valid_d},   32'h0);
    chk("e5_instr", instr_d,            NOP);
    chk("e5_pc",    pc_d,               32'h0);
    chk("e5_pc4",   pc_plus4_d,         32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the RV32I core. It owns the PC and issues one-outstanding word fetches to instruction memory over a request/ready + response-valid handshake. It presents a valid-qualified instruction to decode, whose opcode field feeds the main decoder. It also absorbs decode stalls with a one-entry hold buffer and services branch/jump redirects from execute, discarding any in-flight or buffered fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0013, value driven on instr_d when the slot is empty or flushed (ADDI x0,x0,0)
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; high only in S_REQ and while rst=0
- imem_addr  out  32  fetch address = pc, bits [1:0] always 0
- imem_ready  in  1  memory accepts the request this cycle (handshake = imem_req & imem_ready)
- imem_rvalid  in  1  response valid, never earlier than the cycle after acceptance
- imem_rdata  in  32  fetched instruction word
- stall_d  in  1  decode cannot consume the IF/ID slot this cycle
- redirect  in  1  taken branch/jump from execute, flush request
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0 on load
- valid_d  out  1  IF/ID slot holds a live instruction
- instr_d  out  32  instruction to decode; instr_d[6:0] drives decoder Op
- pc_d  out  32  address of instr_d
- pc_plus4_d  out  32  pc_d + 4, used for JAL/JALR link (ResultSrc=10)

## Operation
- State: pc[31:0], req_pc[31:0] (address of the accepted fetch), hold_instr/hold_pc, FSM state, IF/ID register.
- FSM states:
  - S_REQ: imem_req=1. On accept, req_pc<=pc and go to S_WAIT.
  - S_WAIT: wait for imem_rvalid. On response, if the slot is free, load IF/ID, set pc<=req_pc+4 and go to S_REQ. Otherwise capture the word into the hold buffer, set pc<=req_pc+4 and go to S_HOLD.
  - S_HOLD: no requests are issued. When the slot is free, load IF/ID from the hold buffer and go to S_REQ.
  - S_DROP: wait for the orphaned response and discard it. On imem_rvalid, go to S_REQ.
- Slot free = !valid_d | !stall_d. The decoder consumes the slot on any cycle with valid_d & !stall_d.
- IF/ID update when not redirecting:
  - New word available and slot free: valid_d<=1, instr_d<=word, pc_d<=its address, pc_plus4_d<=address+4.
  - Slot consumed with no new word: valid_d<=0 and instr_d<=NOP_INSTR. pc_d and pc_plus4_d hold.
  - stall_d=1 with valid_d=1: all IF/ID outputs hold.
- Redirect has priority over everything, including stall_d:
  - Always: pc<={redirect_pc[31:2],2'b00}, valid_d<=0, instr_d<=NOP_INSTR, hold buffer invalidated.
  - From S_REQ with accept in the same cycle: go to S_DROP.
  - From S_REQ without accept: stay in S_REQ.
  - From S_WAIT with imem_rvalid in the same cycle: response discarded, go to S_REQ.
  - From S_WAIT without imem_rvalid: go to S_DROP.
  - From S_HOLD: go to S_REQ.
  - From S_DROP with imem_rvalid: go to S_REQ.
  - From S_DROP without imem_rvalid: stay in S_DROP.
- Arithmetic: all PC adds are 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- At most one fetch is outstanding. A second imem_req is never asserted before the prior response has been received or dropped.

## Timing
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=S_REQ.
  - valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0.
  - Hold buffer invalid.
  - imem_req=0 while rst is high.
- Reset mid-operation abandons any outstanding fetch. The memory side must also be reset, since no drop is performed.
- Latency with imem_ready=1 and response one cycle later: request in cycle 0, accept in cycle 0, rvalid in cycle 1, valid_d=1 in cycle 2.
- Peak throughput is 1 instruction per 2 cycles.
- Redirect asserted in cycle N: valid_d=0 from N+1. The first new fetch is requested in N+1 if no response is pending.
- Outputs are registered except imem_req and imem_addr, which are decoded from state and pc.

## Test plan
- Reset then free-run with 1-cycle memory holding 0x00500093 at 0x0 and 0x00A00113 at 0x4.
  - Expect imem_addr 0x0 and then 0x4.
  - Expect valid_d pulses carrying instr_d 0x00500093 (pc_d=0, pc_plus4_d=4), then 0x00A00113 (pc_d=4, pc_plus4_d=8).
- stall_d=1 for 5 cycles while valid_d=1 and a second response arrives.
  - Expect the IF/ID outputs frozen and the FSM in S_HOLD with no imem_req.
  - On release, the held word appears the next cycle and fetching resumes at held pc+4.
- redirect with redirect_pc=0x103 in S_WAIT, response arriving 2 cycles later.
  - Expect S_DROP and the stale word never shown (valid_d stays 0).
  - Next imem_addr is 0x100.
- redirect coincident with imem_rvalid, and separately coincident with stall_d=1 and valid_d=1.
  - Expect valid_d=0 next cycle and instr_d=0x00000013.
- pc=0xFFFFFFFC fetch.
  - Expect pc_plus4_d=0x00000000 and the next imem_addr=0x0.
- rst asserted for 1 cycle while in S_WAIT.
  - Expect all outputs at their reset values and imem_addr=RESET_PC on the next request.
